// File: rtl/ysyx_23060203_axi_sram_pkg.sv
// Shared response codes and FSM state types for the AXI4-lite SRAM responder.
package ysyx_23060203_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_t;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_WAIT,
        W_RESP
    } wstate_t;

endpackage

// File: rtl/ysyx_23060203_axi_sram_if.sv
// AXI4-lite channel bundle; one instance carries either the read or the write path.
interface axi_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport in (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport out (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_23060203_axi_sram_array.sv
// Word-wide storage: combinational read port, byte-enable write port.
// A same-cycle read of the word being written sees the old contents.
module ysyx_23060203_SRAM_ARRAY #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_wstrb
);

    logic [31:0] r_mem [DEPTH_WORDS];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4-lite single-beat SRAM responder with independent read and write FSMs
// and a programmable response latency.
module ysyx_23060203_axi_sram
    import ysyx_23060203_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic clock,
    input  logic reset,
    axi_if.in    mem_r,
    axi_if.in    mem_w
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [7:0] LAT_CNT = 8'(LATENCY);

    // Offset is computed modulo 2^32, so addresses below the base land far above SPAN.
    function automatic logic in_range(input logic [31:0] off);
        return {1'b0, off} < SPAN;
    endfunction

    rstate_t     r_rstate, w_rstate_nxt;
    logic [7:0]  r_rcnt, w_rcnt_nxt;
    logic [31:0] r_araddr, r_rdata;
    logic [1:0]  r_rresp;
    logic        w_rsample;
    logic [31:0] w_raddr, w_roff, w_arr_rdata;

    wstate_t     r_wstate, w_wstate_nxt;
    logic [7:0]  r_wcnt, w_wcnt_nxt;
    logic        r_aw_held, r_w_held;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        w_aw_hs, w_w_hs, w_commit, w_we;
    logic [31:0] w_waddr, w_woff, w_wdata;
    logic [3:0]  w_wstrb;

    // With zero latency the sample/commit happens on the handshake edge itself,
    // so the live bus value is used until it has been captured.
    assign w_raddr = (r_rstate == R_IDLE) ? mem_r.araddr : r_araddr;
    assign w_roff  = w_raddr - ADDR_BASE;
    assign w_waddr = r_aw_held ? r_awaddr : mem_w.awaddr;
    assign w_wdata = r_w_held  ? r_wdata  : mem_w.wdata;
    assign w_wstrb = r_w_held  ? r_wstrb  : mem_w.wstrb;
    assign w_woff  = w_waddr - ADDR_BASE;
    assign w_aw_hs = (r_wstate == W_COLLECT) && !r_aw_held && mem_w.awvalid;
    assign w_w_hs  = (r_wstate == W_COLLECT) && !r_w_held  && mem_w.wvalid;
    assign w_we    = w_commit && in_range(w_woff) && reset;

    ysyx_23060203_SRAM_ARRAY #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock   (clock),
        .i_raddr (w_roff[IDX_W+1:2]),
        .o_rdata (w_arr_rdata),
        .i_we    (w_we),
        .i_waddr (w_woff[IDX_W+1:2]),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb)
    );

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_rcnt_nxt    = r_rcnt;
        w_rsample     = 1'b0;
        mem_r.arready = (r_rstate == R_IDLE);
        mem_r.rvalid  = (r_rstate == R_RESP);
        case (r_rstate)
            R_IDLE: begin
                if (mem_r.arvalid) begin
                    if (LATENCY == 0) begin
                        w_rstate_nxt = R_RESP;
                        w_rsample    = 1'b1;
                    end else begin
                        w_rstate_nxt = R_WAIT;
                        w_rcnt_nxt   = LAT_CNT;
                    end
                end
            end
            R_WAIT: begin
                w_rcnt_nxt = r_rcnt - 8'd1;
                if (r_rcnt == 8'd1) begin
                    w_rstate_nxt = R_RESP;
                    w_rsample    = 1'b1;
                end
            end
            R_RESP: begin
                if (mem_r.rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= 8'd0;
            r_araddr <= 32'd0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rcnt   <= w_rcnt_nxt;
            if (r_rstate == R_IDLE && mem_r.arvalid) r_araddr <= mem_r.araddr;
            if (w_rsample) begin
                r_rdata <= in_range(w_roff) ? w_arr_rdata : 32'd0;
                r_rresp <= in_range(w_roff) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wcnt_nxt    = r_wcnt;
        w_commit      = 1'b0;
        mem_w.awready = (r_wstate == W_COLLECT) && !r_aw_held;
        mem_w.wready  = (r_wstate == W_COLLECT) && !r_w_held;
        mem_w.bvalid  = (r_wstate == W_RESP);
        case (r_wstate)
            W_COLLECT: begin
                if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                    if (LATENCY == 0) begin
                        w_wstate_nxt = W_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_wstate_nxt = W_WAIT;
                        w_wcnt_nxt   = LAT_CNT;
                    end
                end
            end
            W_WAIT: begin
                w_wcnt_nxt = r_wcnt - 8'd1;
                if (r_wcnt == 8'd1) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end
            end
            W_RESP: begin
                if (mem_w.bready) w_wstate_nxt = W_COLLECT;
            end
            default: w_wstate_nxt = W_COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wstate  <= W_COLLECT;
            r_wcnt    <= 8'd0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            if (r_wstate == W_RESP && mem_w.bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= mem_w.awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= mem_w.wdata;
                    r_wstrb  <= mem_w.wstrb;
                end
            end
            if (w_commit) r_bresp <= in_range(w_woff) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign mem_r.rdata = r_rdata;
    assign mem_r.rresp = r_rresp;
    assign mem_w.bresp = r_bresp;

    // Each interface instance carries only one direction; tie off the other half.
    assign mem_r.awready = 1'b0;
    assign mem_r.wready  = 1'b0;
    assign mem_r.bvalid  = 1'b0;
    assign mem_r.bresp   = RESP_OKAY;
    assign mem_w.arready = 1'b0;
    assign mem_w.rvalid  = 1'b0;
    assign mem_w.rdata   = 32'd0;
    assign mem_w.rresp   = RESP_OKAY;

    logic w_unused;
    assign w_unused = ^{mem_r.awaddr, mem_r.awvalid, mem_r.wdata, mem_r.wstrb,
                        mem_r.wvalid, mem_r.bready, mem_w.araddr, mem_w.arvalid,
                        mem_w.rready};

endmodule
